mem_access_sequencer: RTL and testbench

- Control FSM that runs every RAM access on the SPARC datapath: instruction fetch, load and store.
- Drives the MAR/MDR/IR enables, the MAR and MDR source selects, the RAM opcode select and the MFA/MFC handshake.
- Sits between the main control unit and the datapath. It returns one Done pulse per access, or a Timeout pulse if the RAM never answers.

---
 rtl/mem_access_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Control FSM that sequences every RAM access on the SPARC datapath
//   (instruction fetch, load, store). It drives the MAR/MDR/IR load enables,
//   the MAR/MDR source selects, the RAM opcode (OP1/MOP_SEL) and the MFA/MFC
//   handshake. It returns one Done pulse per completed access, or a Timeout
//   pulse when the RAM never answers.
//
// Optional build macro:
//   MISALIGN_CHECK_EN - reject misaligned requests in IDLE (Misalign pulse,
//                       no MAR load, no MFA). Undefined: Misalign is always 0.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous active-high reset
//   FetchReq  in   instruction fetch request (address from PC)
//   LoadReq   in   load request (address from alu_out)
//   StoreReq  in   store request (address from alu_out, data from RF A-port)
//   Size      in   00 word, 01 half, 10 byte, 11 treated as word
//   SignedLd  in   sign-extending load (byte/half only)
//   AddrLo    in   low two address bits of the pending access
//   MFC       in   memory function complete from RAM
//   MARE      out  MAR load enable
//   MAR_SEL   out  MAR source: 00 alu_out, 01 PC, 10 MAR_AUX, 11 zero
//   MDRE      out  MDR load enable
//   MDR_SEL   out  MDR source: 00 RAM data, 01 RF A-port, 10 MDR_AUX, 11 zero
//   IRE       out  IR load enable
//   MFA       out  memory function active to RAM
//   MOP_SEL   out  1: RAM opcode from OP1, 0: from IR opcode field
//   OP1       out  RAM opcode for the current access
//   Busy      out  high in every state except IDLE
//   Done      out  one-cycle pulse on successful completion
//   Timeout   out  one-cycle pulse when the access is aborted
//   Misalign  out  one-cycle pulse when a misaligned request is rejected
module mem_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       FetchReq,
  input  logic       LoadReq,
  input  logic       StoreReq,
  input  logic [1:0] Size,
  input  logic       SignedLd,
  input  logic [1:0] AddrLo,
  input  logic       MFC,
  output logic       MARE,
  output logic [1:0] MAR_SEL,
  output logic       MDRE,
  output logic [1:0] MDR_SEL,
  output logic       IRE,
  output logic       MFA,
  output logic       MOP_SEL,
  output logic [5:0] OP1,
  output logic       Busy,
  output logic       Done,
  output logic       Timeout,
  output logic       Misalign
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_CAPT, S_IRLD, S_DONE, S_ABORT
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mare_q, mare_d;
  logic [1:0]       mar_sel_q, mar_sel_d;
  logic             mdre_q, mdre_d;
  logic [1:0]       mdr_sel_q, mdr_sel_d;
  logic             ire_q, ire_d;
  logic             mfa_q, mfa_d;
  logic             mop_sel_q, mop_sel_d;
  logic [5:0]       op1_q, op1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             misalign_q, misalign_d;

  logic             misaligned;

  // RAM opcode from the latched access kind, size and signedness.
  function automatic logic [5:0] op1_encode(input kind_t kind, input logic [1:0] size,
                                            input logic sgn);
    logic [5:0] op;
    op = 6'b000000;
    case (kind)
      K_LOAD: begin
        case (size)
          2'b01:   op = sgn ? 6'b001010 : 6'b000010;
          2'b10:   op = sgn ? 6'b001001 : 6'b000001;
          default: op = 6'b000000;
        endcase
      end
      K_STORE: begin
        case (size)
          2'b01:   op = 6'b000110;
          2'b10:   op = 6'b000101;
          default: op = 6'b000100;
        endcase
      end
      default: op = 6'b000000;
    endcase
    return op;
  endfunction

`ifdef MISALIGN_CHECK_EN
  // Word (and fetch, latched as word) needs AddrLo==00; halfword needs AddrLo[0]==0.
  always_comb begin
    misaligned = 1'b0;
    if (size_d == 2'b00) begin
      misaligned = (AddrLo != 2'b00);
    end else if (size_d == 2'b01) begin
      misaligned = AddrLo[0];
    end
  end
`else
  // Without the alignment check, the rejection path is never taken and
  // Misalign stays 0.
  logic unused_addr_lo;
  assign unused_addr_lo = ^AddrLo;
  assign misaligned     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (FetchReq || LoadReq || StoreReq) begin
          if (FetchReq) begin
            kind_d = K_FETCH;
            size_d = 2'b00;
            sgn_d  = 1'b0;
          end else if (LoadReq) begin
            kind_d = K_LOAD;
            size_d = (Size == 2'b11) ? 2'b00 : Size;
            sgn_d  = SignedLd;
          end else begin
            kind_d = K_STORE;
            size_d = (Size == 2'b11) ? 2'b00 : Size;
            sgn_d  = 1'b0;
          end
          mis_d   = misaligned;
          state_d = misaligned ? S_ABORT : S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // MFC wins over the timeout check, even on the last allowed cycle.
        if (MFC) begin
          state_d = (kind_q == K_STORE) ? S_DONE : S_CAPT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d = S_ABORT;
          end
        end
      end
      S_CAPT:  state_d = (kind_q == K_FETCH) ? S_IRLD : S_DONE;
      S_IRLD:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs decode the next state so the registered copy lines up with it.
    mare_d     = (state_d == S_ADDR);
    mar_sel_d  = (state_d == S_ADDR && kind_d == K_FETCH) ? 2'b01 : 2'b00;
    mdre_d     = (state_d == S_ADDR && kind_d == K_STORE) || (state_d == S_CAPT);
    mdr_sel_d  = (state_d == S_ADDR && kind_d == K_STORE) ? 2'b01 : 2'b00;
    ire_d      = (state_d == S_IRLD);
    // MFA is held through CAPT so RAM data stays stable while MDR loads.
    mfa_d      = (state_d == S_WAIT) || (state_d == S_CAPT);
    mop_sel_d  = (state_d == S_ADDR) || (state_d == S_WAIT) || (state_d == S_CAPT);
    op1_d      = mop_sel_d ? op1_encode(kind_d, size_d, sgn_d) : 6'b000000;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    timeout_d  = (state_d == S_ABORT) && !mis_d;
    misalign_d = (state_d == S_ABORT) && mis_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      kind_q     <= K_FETCH;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
      mare_q     <= 1'b0;
      mar_sel_q  <= 2'b00;
      mdre_q     <= 1'b0;
      mdr_sel_q  <= 2'b00;
      ire_q      <= 1'b0;
      mfa_q      <= 1'b0;
      mop_sel_q  <= 1'b0;
      op1_q      <= 6'b000000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
      mare_q     <= mare_d;
      mar_sel_q  <= mar_sel_d;
      mdre_q     <= mdre_d;
      mdr_sel_q  <= mdr_sel_d;
      ire_q      <= ire_d;
      mfa_q      <= mfa_d;
      mop_sel_q  <= mop_sel_d;
      op1_q      <= op1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      misalign_q <= misalign_d;
    end
  end

  assign MARE     = mare_q;
  assign MAR_SEL  = mar_sel_q;
  assign MDRE     = mdre_q;
  assign MDR_SEL  = mdr_sel_q;
  assign IRE      = ire_q;
  assign MFA      = mfa_q;
  assign MOP_SEL  = mop_sel_q;
  assign OP1      = op1_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Timeout  = timeout_q;
  assign Misalign = misalign_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed testbench for mem_access_sequencer. Cycle n is sampled 1 time unit
// after the n-th rising edge following the cycle in which a request is raised.
module tb_mem_access_sequencer;

  logic       Clk;
  logic       Reset;
  logic       FetchReq;
  logic       LoadReq;
  logic       StoreReq;
  logic [1:0] Size;
  logic       SignedLd;
  logic [1:0] AddrLo;
  logic       MFC;
  logic       MARE;
  logic [1:0] MAR_SEL;
  logic       MDRE;
  logic [1:0] MDR_SEL;
  logic       IRE;
  logic       MFA;
  logic       MOP_SEL;
  logic [5:0] OP1;
  logic       Busy;
  logic       Done;
  logic       Timeout;
  logic       Misalign;

  int n_run;
  int n_fail;

  logic [18:0] all_out;
  assign all_out = {MARE, MAR_SEL, MDRE, MDR_SEL, IRE, MFA, MOP_SEL, OP1,
                    Busy, Done, Timeout, Misalign};

  mem_access_sequencer #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .FetchReq(FetchReq), .LoadReq(LoadReq),
    .StoreReq(StoreReq), .Size(Size), .SignedLd(SignedLd), .AddrLo(AddrLo),
    .MFC(MFC), .MARE(MARE), .MAR_SEL(MAR_SEL), .MDRE(MDRE), .MDR_SEL(MDR_SEL),
    .IRE(IRE), .MFA(MFA), .MOP_SEL(MOP_SEL), .OP1(OP1), .Busy(Busy),
    .Done(Done), .Timeout(Timeout), .Misalign(Misalign)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; FetchReq = 1'b0; LoadReq = 1'b0; StoreReq = 1'b0;
    Size = 2'b00; SignedLd = 1'b0; AddrLo = 2'b00; MFC = 1'b0;
    step(); step();
    n_run++;
    if (all_out !== 19'd0) begin
      $display("FAIL reset_outputs: got %0h expected 0", all_out); n_fail++;
    end
    Reset = 1'b0;
    step();
    n_run++;
    if (all_out !== 19'd0) begin
      $display("FAIL idle_outputs: got %0h expected 0", all_out); n_fail++;
    end
  endtask

  task automatic test_fetch();
    int ire_seen;
    ire_seen = 0;
    FetchReq = 1'b1; Size = 2'b10; AddrLo = 2'b00;
    step(); // cycle 1: ADDR
    n_run++;
    if ({MARE, MAR_SEL, MFA, Busy, MOP_SEL, OP1} !== {1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 6'b000000}) begin
      $display("FAIL fetch_c1: got MARE=%0b MAR_SEL=%0b MFA=%0b Busy=%0b MOP_SEL=%0b OP1=%b expected 1 01 0 1 1 000000",
               MARE, MAR_SEL, MFA, Busy, MOP_SEL, OP1); n_fail++;
    end
    FetchReq = 1'b0;
    step(); // cycle 2: WAIT
    n_run++;
    if ({MARE, MFA, MDRE, OP1} !== {1'b0, 1'b1, 1'b0, 6'b000000}) begin
      $display("FAIL fetch_c2: got MARE=%0b MFA=%0b MDRE=%0b OP1=%b expected 0 1 0 000000",
               MARE, MFA, MDRE, OP1); n_fail++;
    end
    MFC = 1'b1;
    step(); // cycle 3: CAPT
    MFC = 1'b0;
    n_run++;
    if ({MFA, MDRE, MDR_SEL, IRE, OP1} !== {1'b1, 1'b1, 2'b00, 1'b0, 6'b000000}) begin
      $display("FAIL fetch_c3: got MFA=%0b MDRE=%0b MDR_SEL=%0b IRE=%0b OP1=%b expected 1 1 00 0 000000",
               MFA, MDRE, MDR_SEL, IRE, OP1); n_fail++;
    end
    step(); // cycle 4: IRLD
    n_run++;
    if ({IRE, MFA, MDRE, Done} !== 4'b1000) begin
      $display("FAIL fetch_c4: got IRE=%0b MFA=%0b MDRE=%0b Done=%0b expected 1 0 0 0",
               IRE, MFA, MDRE, Done); n_fail++;
    end
    step(); // cycle 5: DONE
    n_run++;
    if ({Done, Busy, IRE} !== 3'b110) begin
      $display("FAIL fetch_c5: got Done=%0b Busy=%0b IRE=%0b expected 1 1 0", Done, Busy, IRE); n_fail++;
    end
    step(); // cycle 6: IDLE
    n_run++;
    if ({Done, Busy} !== 2'b00) begin
      $display("FAIL fetch_c6: got Done=%0b Busy=%0b expected 0 0", Done, Busy); n_fail++;
    end
  endtask

  task automatic test_store_byte();
    int ire_seen;
    int mfa_cnt;
    int op_bad;
    ire_seen = 0; mfa_cnt = 0; op_bad = 0;
    StoreReq = 1'b1; Size = 2'b10; AddrLo = 2'b11;
    step(); // cycle 1: ADDR
    n_run++;
    if ({MARE, MAR_SEL, MDRE, MDR_SEL} !== {1'b1, 2'b00, 1'b1, 2'b01}) begin
      $display("FAIL store_addr: got MARE=%0b MAR_SEL=%0b MDRE=%0b MDR_SEL=%0b expected 1 00 1 01",
               MARE, MAR_SEL, MDRE, MDR_SEL); n_fail++;
    end
    StoreReq = 1'b0;
    for (int i = 0; i < 3; i++) begin // cycles 2..4: WAIT, MFC in the third
      step();
      if (MFA === 1'b1) mfa_cnt++;
      if (OP1 !== 6'b000101) op_bad++;
      if (IRE !== 1'b0) ire_seen++;
      if (i == 2) MFC = 1'b1;
    end
    step(); // cycle 5: DONE
    MFC = 1'b0;
    if (IRE !== 1'b0) ire_seen++;
    n_run++;
    if (mfa_cnt != 3 || MFA !== 1'b0) begin
      $display("FAIL store_mfa: got %0d cycles (MFA now %0b) expected 3 (now 0)", mfa_cnt, MFA); n_fail++;
    end
    n_run++;
    if (op_bad != 0) begin
      $display("FAIL store_op1: got %0d cycles without 000101 expected 0", op_bad); n_fail++;
    end
    n_run++;
    if (Done !== 1'b1) begin
      $display("FAIL store_done: got %0b expected 1", Done); n_fail++;
    end
    n_run++;
    if (ire_seen != 0) begin
      $display("FAIL store_ire: got %0d IRE cycles expected 0", ire_seen); n_fail++;
    end
    step();
  endtask

  task automatic test_load_timeout();
    int mfa_cnt;
    int op_bad;
    int mdre_seen;
    mfa_cnt = 0; op_bad = 0; mdre_seen = 0;
    LoadReq = 1'b1; Size = 2'b01; SignedLd = 1'b1; AddrLo = 2'b00; MFC = 1'b0;
    step(); // cycle 1: ADDR
    if (MDRE !== 1'b0) mdre_seen++;
    LoadReq = 1'b0; SignedLd = 1'b0;
    for (int i = 0; i < 15; i++) begin // cycles 2..16
      step();
      if (MFA === 1'b1) mfa_cnt++;
      if (OP1 !== 6'b001010) op_bad++;
      if (MDRE !== 1'b0) mdre_seen++;
    end
    step(); // cycle 17: ABORT
    if (MDRE !== 1'b0) mdre_seen++;
    n_run++;
    if (mfa_cnt != 15) begin
      $display("FAIL ld_to_mfa_cycles: got %0d expected 15", mfa_cnt); n_fail++;
    end
    n_run++;
    if (op_bad != 0) begin
      $display("FAIL ld_to_op1: got %0d cycles without 001010 expected 0", op_bad); n_fail++;
    end
    n_run++;
    if ({Timeout, MFA, Busy, Done, Misalign} !== 5'b10100) begin
      $display("FAIL ld_to_abort: got Timeout=%0b MFA=%0b Busy=%0b Done=%0b Misalign=%0b expected 1 0 1 0 0",
               Timeout, MFA, Busy, Done, Misalign); n_fail++;
    end
    step(); // cycle 18: IDLE
    n_run++;
    if ({Timeout, Busy} !== 2'b00) begin
      $display("FAIL ld_to_idle: got Timeout=%0b Busy=%0b expected 0 0", Timeout, Busy); n_fail++;
    end
    n_run++;
    if (mdre_seen != 0) begin
      $display("FAIL ld_to_mdre: got %0d MDRE cycles expected 0", mdre_seen); n_fail++;
    end
  endtask

  task automatic test_timeout_edge();
    LoadReq = 1'b1; Size = 2'b10; SignedLd = 1'b0; AddrLo = 2'b01; MFC = 1'b0;
    step(); // cycle 1
    LoadReq = 1'b0;
    for (int i = 0; i < 15; i++) begin // cycles 2..16, MFC on the last one
      step();
      if (i == 14) MFC = 1'b1;
    end
    step(); // cycle 17: CAPT
    MFC = 1'b0;
    n_run++;
    if ({MDRE, MFA, Timeout, OP1} !== {1'b1, 1'b1, 1'b0, 6'b000001}) begin
      $display("FAIL edge_capt: got MDRE=%0b MFA=%0b Timeout=%0b OP1=%b expected 1 1 0 000001",
               MDRE, MFA, Timeout, OP1); n_fail++;
    end
    step(); // cycle 18: DONE
    n_run++;
    if ({Done, Timeout} !== 2'b10) begin
      $display("FAIL edge_done: got Done=%0b Timeout=%0b expected 1 0", Done, Timeout); n_fail++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    FetchReq = 1'b1; StoreReq = 1'b1; Size = 2'b00; AddrLo = 2'b00; MFC = 1'b1;
    step(); // cycle 1: fetch ADDR
    n_run++;
    if ({MARE, MAR_SEL, MDRE} !== {1'b1, 2'b01, 1'b0}) begin
      $display("FAIL b2b_fetch_first: got MARE=%0b MAR_SEL=%0b MDRE=%0b expected 1 01 0",
               MARE, MAR_SEL, MDRE); n_fail++;
    end
    FetchReq = 1'b0;
    step(); step(); step(); step(); // cycle 5: DONE
    n_run++;
    if (Done !== 1'b1) begin
      $display("FAIL b2b_fetch_done: got %0b expected 1", Done); n_fail++;
    end
    step(); // cycle 6: IDLE, store sampled
    n_run++;
    if ({Busy, Done} !== 2'b00) begin
      $display("FAIL b2b_idle: got Busy=%0b Done=%0b expected 0 0", Busy, Done); n_fail++;
    end
    step(); // cycle 7: store ADDR
    n_run++;
    if ({MARE, MAR_SEL, MDRE, MDR_SEL} !== {1'b1, 2'b00, 1'b1, 2'b01}) begin
      $display("FAIL b2b_store_addr: got MARE=%0b MAR_SEL=%0b MDRE=%0b MDR_SEL=%0b expected 1 00 1 01",
               MARE, MAR_SEL, MDRE, MDR_SEL); n_fail++;
    end
    StoreReq = 1'b0;
    step(); // cycle 8: WAIT, MFC already high
    n_run++;
    if ({MFA, OP1} !== {1'b1, 6'b000100}) begin
      $display("FAIL b2b_store_wait: got MFA=%0b OP1=%b expected 1 000100", MFA, OP1); n_fail++;
    end
    step(); // cycle 9: DONE
    MFC = 1'b0;
    n_run++;
    if ({Done, MFA} !== 2'b10) begin
      $display("FAIL b2b_store_done: got Done=%0b MFA=%0b expected 1 0", Done, MFA); n_fail++;
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    LoadReq = 1'b1; Size = 2'b00; AddrLo = 2'b00; MFC = 1'b0;
    step(); // cycle 1
    LoadReq = 1'b0;
    step(); // cycle 2: WAIT
    n_run++;
    if (MFA !== 1'b1) begin
      $display("FAIL rst_pre_mfa: got %0b expected 1", MFA); n_fail++;
    end
    #2;
    Reset = 1'b1;
    #1;
    n_run++;
    if (all_out !== 19'd0) begin
      $display("FAIL rst_async: got %0h expected 0", all_out); n_fail++;
    end
    step();
    Reset = 1'b0;
    LoadReq = 1'b1; Size = 2'b10; SignedLd = 1'b1;
    step(); // cycle 1
    LoadReq = 1'b0; SignedLd = 1'b0;
    n_run++;
    if ({MARE, MAR_SEL} !== {1'b1, 2'b00}) begin
      $display("FAIL rst_reload_addr: got MARE=%0b MAR_SEL=%0b expected 1 00", MARE, MAR_SEL); n_fail++;
    end
    step(); // cycle 2: WAIT
    n_run++;
    if (OP1 !== 6'b001001) begin
      $display("FAIL rst_reload_op1: got %b expected 001001", OP1); n_fail++;
    end
    MFC = 1'b1;
    step(); // cycle 3: CAPT
    MFC = 1'b0;
    step(); // cycle 4: DONE
    n_run++;
    if ({Done, IRE} !== 2'b10) begin
      $display("FAIL rst_reload_done: got Done=%0b IRE=%0b expected 1 0", Done, IRE); n_fail++;
    end
    step();
  endtask

  task automatic test_misalign();
    int mare_seen;
    int mfa_seen;
    mare_seen = 0; mfa_seen = 0;
`ifdef MISALIGN_CHECK_EN
    LoadReq = 1'b1; Size = 2'b00; AddrLo = 2'b10; MFC = 1'b0;
    step(); // cycle 1: ABORT
    LoadReq = 1'b0;
    if (MARE !== 1'b0) mare_seen++;
    if (MFA !== 1'b0) mfa_seen++;
    n_run++;
    if ({Misalign, Timeout, Busy} !== 3'b101) begin
      $display("FAIL mis_pulse: got Misalign=%0b Timeout=%0b Busy=%0b expected 1 0 1",
               Misalign, Timeout, Busy); n_fail++;
    end
    step(); // cycle 2: IDLE
    if (MARE !== 1'b0) mare_seen++;
    if (MFA !== 1'b0) mfa_seen++;
    n_run++;
    if ({Misalign, Busy} !== 2'b00) begin
      $display("FAIL mis_end: got Misalign=%0b Busy=%0b expected 0 0", Misalign, Busy); n_fail++;
    end
    n_run++;
    if (mare_seen != 0 || mfa_seen != 0) begin
      $display("FAIL mis_no_access: got MARE cycles=%0d MFA cycles=%0d expected 0 0",
               mare_seen, mfa_seen); n_fail++;
    end
    // Halfword at AddrLo=10 is aligned and must proceed.
    LoadReq = 1'b1; Size = 2'b01; AddrLo = 2'b10; MFC = 1'b1;
    step();
    LoadReq = 1'b0;
    n_run++;
    if ({MARE, Misalign} !== 2'b10) begin
      $display("FAIL mis_half_ok: got MARE=%0b Misalign=%0b expected 1 0", MARE, Misalign); n_fail++;
    end
    step(); step(); step(); // cycle 4: DONE
    MFC = 1'b0;
    n_run++;
    if (Done !== 1'b1) begin
      $display("FAIL mis_half_done: got %0b expected 1", Done); n_fail++;
    end
    step();
`else
    // Without the check, a misaligned word load runs like any other.
    LoadReq = 1'b1; Size = 2'b00; AddrLo = 2'b10; MFC = 1'b1;
    step(); // cycle 1
    LoadReq = 1'b0;
    if (Misalign !== 1'b0) mfa_seen++;
    n_run++;
    if (MARE !== 1'b1) begin
      $display("FAIL nomis_addr: got MARE=%0b expected 1", MARE); n_fail++;
    end
    step(); step(); step(); // cycle 4: DONE
    MFC = 1'b0;
    if (Misalign !== 1'b0) mfa_seen++;
    n_run++;
    if ({Done, Timeout} !== 2'b10) begin
      $display("FAIL nomis_done: got Done=%0b Timeout=%0b expected 1 0", Done, Timeout); n_fail++;
    end
    n_run++;
    if (mfa_seen != 0 || mare_seen != 0) begin
      $display("FAIL nomis_flag: got %0d Misalign cycles expected 0", mfa_seen); n_fail++;
    end
    step();
`endif
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_fetch();
    test_store_byte();
    test_load_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid_wait();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
